// File: rtl/pong_pkg.sv
// ============================================================================
// Module : pong_pkg
// Brief  : Shared geometry and width constants for the pong display path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pong_pkg;
    localparam int GLYPH_W    = 8;
    localparam int GLYPH_H    = 16;
    localparam int SCALE      = 2;
    localparam int ROM_ADDR_W = 8;
    localparam int PIX_W      = 10;
    localparam int SCORE_W    = 4;
    localparam int REGION_W   = GLYPH_W * SCALE;
    localparam int REGION_H   = GLYPH_H * SCALE;
endpackage

`default_nettype wire

// File: rtl/score_counter.sv
// ============================================================================
// Module : score_counter
// Brief  : Saturating per-player score register with clear and hold.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_counter
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = 9
) (
    input  logic               P_CLK,
    input  logic               P_RST,
    input  logic               point,
    input  logic               clear,
    input  logic               hold,
    output logic [SCORE_W-1:0] score,
    output logic               at_win
);

    localparam logic [SCORE_W-1:0] c_win = SCORE_W'(WIN_SCORE);

    logic [SCORE_W-1:0] r_score;

    always_ff @(posedge P_CLK or posedge P_RST) begin
        if (P_RST) begin
            r_score <= '0;
        end else if (clear) begin
            r_score <= '0;
        end else if (point && !hold && (r_score < c_win)) begin
            r_score <= r_score + 1'b1;
        end
    end

    assign score  = r_score;
    assign at_win = (r_score == c_win);

endmodule

`default_nettype wire

// File: rtl/score_overlay.sv
// ============================================================================
// Module : score_overlay
// Brief  : Score keeping, match-end detection and 2-stage glyph rendering.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module score_overlay
    import pong_pkg::*;
#(
    parameter int LEFT_X    = 256,
    parameter int RIGHT_X   = 368,
    parameter int TOP_Y     = 32,
    parameter int WIN_SCORE = 9
) (
    input  logic                  P_CLK,
    input  logic                  P_RST,
    input  logic [PIX_W-1:0]      pix_x,
    input  logic [PIX_W-1:0]      pix_y,
    input  logic                  video_on,
    input  logic                  frame_tick,
    input  logic                  point_l,
    input  logic                  point_r,
    input  logic                  new_game,
    input  logic [7:0]            rom_data,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic [SCORE_W-1:0]    score_l,
    output logic [SCORE_W-1:0]    score_r,
    output logic                  game_over,
    output logic                  score_on
);

    localparam logic [PIX_W-1:0] c_left_x   = PIX_W'(LEFT_X);
    localparam logic [PIX_W-1:0] c_right_x  = PIX_W'(RIGHT_X);
    localparam logic [PIX_W-1:0] c_top_y    = PIX_W'(TOP_Y);
    localparam logic [PIX_W-1:0] c_region_w = PIX_W'(REGION_W);
    localparam logic [PIX_W-1:0] c_region_h = PIX_W'(REGION_H);

    logic                 w_at_win_l;
    logic                 w_at_win_r;
    logic                 r_game_over;
    logic [SCORE_W-1:0]   r_disp_l;
    logic [SCORE_W-1:0]   r_disp_r;
    logic [PIX_W-1:0]     w_dx_l;
    logic [PIX_W-1:0]     w_dx_r;
    logic [PIX_W-1:0]     w_dy;
    logic                 w_in_y;
    logic                 w_reg_l;
    logic                 w_reg_r;
    logic [2:0]           w_col;
    logic [SCORE_W-1:0]   w_sel_digit;
    logic                 r_hit;
    logic [2:0]           r_bit_sel;
    logic                 r_score_on;

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_cnt_l (
        .P_CLK  (P_CLK),
        .P_RST  (P_RST),
        .point  (point_l),
        .clear  (new_game),
        .hold   (r_game_over),
        .score  (score_l),
        .at_win (w_at_win_l)
    );

    score_counter #(.WIN_SCORE(WIN_SCORE)) u_cnt_r (
        .P_CLK  (P_CLK),
        .P_RST  (P_RST),
        .point  (point_r),
        .clear  (new_game),
        .hold   (r_game_over),
        .score  (score_r),
        .at_win (w_at_win_r)
    );

    always_ff @(posedge P_CLK or posedge P_RST) begin
        if (P_RST) begin
            r_game_over <= 1'b0;
        end else if (new_game) begin
            r_game_over <= 1'b0;
        end else if (w_at_win_l || w_at_win_r) begin
            r_game_over <= 1'b1;
        end
    end

    // Shadows change only at frame start so a glyph never tears mid-frame.
    always_ff @(posedge P_CLK or posedge P_RST) begin
        if (P_RST) begin
            r_disp_l <= '0;
            r_disp_r <= '0;
        end else if (frame_tick) begin
            r_disp_l <= score_l;
            r_disp_r <= score_r;
        end
    end

    // Explicit >= keeps pixels left of / above a region from wrapping into it.
    assign w_dx_l  = pix_x - c_left_x;
    assign w_dx_r  = pix_x - c_right_x;
    assign w_dy    = pix_y - c_top_y;
    assign w_in_y  = (pix_y >= c_top_y) && (w_dy < c_region_h);
    assign w_reg_l = w_in_y && (pix_x >= c_left_x) && (w_dx_l < c_region_w);
    assign w_reg_r = w_in_y && (pix_x >= c_right_x) && (w_dx_r < c_region_w) && !w_reg_l;

    always_comb begin
        w_sel_digit = '0;
        w_col       = w_dx_r[3:1];
        if (w_reg_l) begin
            w_sel_digit = r_disp_l;
            w_col       = w_dx_l[3:1];
        end else if (w_reg_r) begin
            w_sel_digit = r_disp_r;
        end
    end

    assign rom_addr = {w_sel_digit, w_dy[4:1]};

    always_ff @(posedge P_CLK or posedge P_RST) begin
        if (P_RST) begin
            r_hit      <= 1'b0;
            r_bit_sel  <= '0;
            r_score_on <= 1'b0;
        end else begin
            r_hit      <= (w_reg_l || w_reg_r) && video_on;
            r_bit_sel  <= 3'd7 - w_col;
            r_score_on <= r_hit && rom_data[r_bit_sel];
        end
    end

    assign game_over = r_game_over;
    assign score_on  = r_score_on;

endmodule

`default_nettype wire

// File: tb/tb_score_overlay.sv
// ============================================================================
// Module : tb_score_overlay
// Brief  : Self-checking bench for score_overlay against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_score_overlay;

    localparam int LEFT_X  = 256;
    localparam int RIGHT_X = 368;
    localparam int TOP_Y   = 32;
    localparam int WIN     = 9;

    logic       P_CLK = 1'b0;
    logic       P_RST;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_on;
    logic       frame_tick;
    logic       point_l;
    logic       point_r;
    logic       new_game;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] rom_addr;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       game_over;
    logic       score_on;

    logic [7:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_l, m_r, m_go, m_dl, m_dr, m_p1, m_exp_on;

    score_overlay #(
        .LEFT_X(LEFT_X), .RIGHT_X(RIGHT_X), .TOP_Y(TOP_Y), .WIN_SCORE(WIN)
    ) dut (
        .P_CLK      (P_CLK),
        .P_RST      (P_RST),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .video_on   (video_on),
        .frame_tick (frame_tick),
        .point_l    (point_l),
        .point_r    (point_r),
        .new_game   (new_game),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .score_on   (score_on)
    );

    always #5 P_CLK = ~P_CLK;

    always @(posedge P_CLK) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int region(input int x, input int y);
        int dy = y - TOP_Y;
        if (dy < 0 || dy >= 32) return 0;
        if (x >= LEFT_X && x < LEFT_X + 16) return 1;
        if (x >= RIGHT_X && x < RIGHT_X + 16) return 2;
        return 0;
    endfunction

    function automatic int exp_addr(input int x, input int y);
        int reg_id = region(x, y);
        int digit  = (reg_id == 1) ? m_dl : (reg_id == 2) ? m_dr : 0;
        int row    = (((y - TOP_Y + 1024) % 1024) / 2) % 16;
        return digit * 16 + row;
    endfunction

    function automatic int exp_pix(input int x, input int y, input int vo);
        int reg_id = region(x, y);
        logic [7:0] g;
        int col;
        if (vo == 0 || reg_id == 0) return 0;
        g   = rom[exp_addr(x, y)];
        col = (reg_id == 1) ? (x - LEFT_X) / 2 : (x - RIGHT_X) / 2;
        return int'(g[7 - col]);
    endfunction

    task automatic model_reset();
        m_l = 0; m_r = 0; m_go = 0; m_dl = 0; m_dr = 0; m_p1 = 0; m_exp_on = 0;
    endtask

    task automatic cyc();
        int nl, nr, ngo;
        @(posedge P_CLK);
        #1;
        if (P_RST) begin
            model_reset();
        end else begin
            m_exp_on = m_p1;
            m_p1     = exp_pix(int'(pix_x), int'(pix_y), int'(video_on));
            nl  = new_game ? 0 : (point_l && m_go == 0 && m_l < WIN) ? m_l + 1 : m_l;
            nr  = new_game ? 0 : (point_r && m_go == 0 && m_r < WIN) ? m_r + 1 : m_r;
            ngo = new_game ? 0 : (m_l == WIN || m_r == WIN) ? 1 : m_go;
            if (frame_tick) begin
                m_dl = m_l;
                m_dr = m_r;
            end
            m_l = nl; m_r = nr; m_go = ngo;
        end
        chk("score_l", int'(score_l), m_l);
        chk("score_r", int'(score_r), m_r);
        chk("game_over", int'(game_over), m_go);
        chk("score_on", int'(score_on), m_exp_on);
    endtask

    task automatic drive(input int x, input int y, input int vo, input int ft,
                         input int pl, input int pr, input int ng);
        pix_x      = 10'(x);
        pix_y      = 10'(y);
        video_on   = (vo != 0);
        frame_tick = (ft != 0);
        point_l    = (pl != 0);
        point_r    = (pr != 0);
        new_game   = (ng != 0);
        #1;
        chk("rom_addr", int'(rom_addr), exp_addr(x, y));
        cyc();
    endtask

    initial begin
        int xs[4];
        int ys[4];
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        rom[8'h02] = 8'h7C;
        model_reset();
        P_RST = 1'b1;
        pix_x = '0; pix_y = '0; video_on = 1'b0; frame_tick = 1'b0;
        point_l = 1'b0; point_r = 1'b0; new_game = 1'b0;

        drive(0, 0, 0, 0, 0, 0, 0);
        drive(258, 36, 1, 1, 1, 1, 0);
        chk("rst_score_l", int'(score_l), 0);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_score_on", int'(score_on), 0);
        P_RST = 1'b0;

        // scoring to win
        repeat (3) drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("score_l_4", int'(score_l), 4);
        chk("score_r_1", int'(score_r), 1);
        repeat (5) drive(0, 0, 0, 0, 1, 0, 0);
        chk("score_l_9", int'(score_l), 9);
        chk("go_not_yet", int'(game_over), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("go_set", int'(game_over), 1);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("score_l_sat", int'(score_l), 9);
        chk("score_r_held", int'(score_r), 1);

        // new_game beats point_r
        drive(0, 0, 0, 0, 0, 1, 1);
        chk("ng_score_l", int'(score_l), 0);
        chk("ng_score_r", int'(score_r), 0);
        chk("ng_go", int'(game_over), 0);

        // digit 0 rendering
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(258, 36, 1, 0, 0, 0, 0);
        chk("addr_258_36", int'(rom_addr), 8'h02);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("on_258_36", int'(score_on), 1);
        drive(256, 36, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("on_256_36", int'(score_on), 0);

        // boundaries, lit and blanked
        xs = '{255, 256, 271, 272};
        ys = '{31, 32, 63, 64};
        repeat (3) drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 0);
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    drive(xs[i], ys[j], 1 - v, 0, 0, 0, 0);
        drive(RIGHT_X + 15, 63, 1, 0, 0, 0, 0);
        drive(RIGHT_X + 16, 40, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // tearing: shadow holds until frame_tick
        drive(260, 40, 1, 0, 1, 0, 0);
        drive(260, 40, 1, 0, 0, 0, 0);
        chk("tear_hold", int'(rom_addr[7:4]), 3);
        drive(260, 40, 1, 1, 0, 0, 0);
        chk("tear_update", int'(rom_addr[7:4]), 4);

        // randomized traffic with a mid-line async reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #3;
                P_RST = 1'b1;
                #1;
                model_reset();
                chk("arst_score_l", int'(score_l), 0);
                chk("arst_score_r", int'(score_r), 0);
                chk("arst_go", int'(game_over), 0);
                chk("arst_score_on", int'(score_on), 0);
                drive(260, 40, 1, 0, 1, 0, 0);
                P_RST = 1'b0;
            end
            drive($urandom_range(250, 390), $urandom_range(26, 70),
                  ($urandom_range(0, 7) != 0) ? 1 : 0,
                  ($urandom_range(0, 15) == 0) ? 1 : 0,
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  ($urandom_range(0, 5) == 0) ? 1 : 0,
                  ($urandom_range(0, 59) == 0) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/score_overlay.md
# score_overlay

Score-keeping and score-rendering block for the pong display path. Holds the left/right player scores (0–9 each), detects match end, and renders both scores as scaled glyphs by reading `digit_rom`. It drives `rom_addr` from the live pixel position and consumes `rom_data` one cycle later. It outputs a pipelined per-pixel `score_on` flag that the pixel mixer ORs into the RGB path.

## Interface
- `LEFT_X`, default 256: left glyph left edge (pixel column)
- `RIGHT_X`, default 368: right glyph left edge
- `TOP_Y`, default 32: top edge of both glyphs (pixel row)
- `WIN_SCORE`, default 9: score that ends the match (1..9)

Ports:
- `P_CLK` in 1: pixel clock, all logic rising-edge
- `P_RST` in 1: reset. Asynchronous, active-high.
- `pix_x` in 10: current pixel column
- `pix_y` in 10: current pixel row
- `video_on` in 1: visible-area flag aligned with `pix_x`/`pix_y`
- `frame_tick` in 1: one-cycle pulse at frame start; latches the displayed scores
- `point_l` in 1: one-cycle pulse, left player scored
- `point_r` in 1: one-cycle pulse, right player scored
- `new_game` in 1: one-cycle pulse, clears scores and `game_over`
- `rom_data` in 8: glyph row from `digit_rom`; MSB is the leftmost pixel
- `rom_addr` out 8: `{digit[3:0], glyph_row[3:0]}` to `digit_rom`
- `score_l` out 4: live left score
- `score_r` out 4: live right score
- `game_over` out 1: sticky, set when either score reaches `WIN_SCORE`
- `score_on` out 1: pixel belongs to a lit score glyph

## Operation
- **Reset values:** `score_l`, `score_r`, displayed shadows, pipeline registers and `score_on` reset to 0; `game_over` resets to 0.
- **Score update** (per player, registered):
  - If `new_game` is high, clear the score to 0. This takes priority over points in the same cycle.
  - Otherwise, if `point_x` is high and `game_over` is 0, increment the score.
  - `point_l` and `point_r` in the same cycle both increment.
  - A score never exceeds `WIN_SCORE`; no wrap.
- **`game_over`:**
  - Set on the cycle after either score register becomes `WIN_SCORE`.
  - Cleared only by `new_game` or reset.
  - While `game_over` is 1, points are ignored.
- **Display shadows:**
  - `disp_l`/`disp_r` load `score_l`/`score_r` on `frame_tick` only, so no mid-frame tearing.
  - On `new_game`, the shadows still update only at the next `frame_tick`.
- **Glyph geometry:**
  - Each 8×16 glyph is scaled ×2, giving a 16×32 pixel region.
  - `dx = pix_x - LEFT_X` (or `RIGHT_X`); `dy = pix_y - TOP_Y`.
  - The left region is hit when `0 <= dx < 16` and `0 <= dy < 32`; the right region likewise.
  - The regions must not overlap; the left region takes priority if they do.
- **Address generation (combinational):**
  - `rom_addr = {sel_digit, dy[4:1]}`.
  - `sel_digit` is `disp_l` in the left region, `disp_r` in the right region, 0 outside both.
- **Stage 1 registers:** `hit = region & video_on` and `bit_sel = 7 - dx[3:1]` (3 bits).
- **Stage 2:** `score_on <= hit_d & rom_data[bit_sel_d]`.
- **Address width:** unsigned 10-bit compare. `pix_x < LEFT_X` must fail the hit test, so use an explicit `>=` compare, not wrapped subtraction.

## Timing
- **ROM latency:** `digit_rom` registers its address on `P_CLK`, so `rom_data` is valid one cycle after `rom_addr`.
- **Pixel latency:** `score_on` for pixel (x,y) presented at cycle N is valid at N+2 (registered output). The mixer delays RGB to match.
- **Point latency:** `point_x` at cycle N gives the new score at N+1 and `game_over` (if reached) at N+2.
- **Display latency:** a score change is shown from the first `frame_tick` after it.
- **Reset mid-line:** `score_on` is forced to 0 immediately (async). Correct output resumes two cycles after reset release.

## Structure
- Shared package `pong_pkg`:
  - `GLYPH_W = 8`, `GLYPH_H = 16`, `SCALE = 2`, `ROM_ADDR_W = 8`
  - `PIX_W = 10`, `SCORE_W = 4`
- One sub-module, `score_counter`:
  - Inputs: `P_CLK`, `P_RST`, `point`, `clear`, `hold`.
  - Outputs: `score[3:0]`, `at_win`.
  - Instantiated twice (left, right).
- Render pipeline and `game_over` live in the top.

## Test plan
- **Reset:** assert `P_RST` asynchronously mid-line → `score_l = score_r = 0`, `game_over = 0`, `score_on = 0` within the same cycle.
- **Scoring to win:**
  - Stimulus: 3 `point_l` pulses, then a simultaneous `point_l`/`point_r`.
  - Expect `score_l = 4`, `score_r = 1`.
  - Continue to `score_l = 9` → `game_over = 1` the cycle after; a further `point_l` leaves the score at 9.
- **Priority:** `new_game` together with `point_r` → both scores 0 and `game_over = 0` next cycle.
- **Render digit 0 at the left region:**
  - Set `disp_l = 0`; present `pix_x = 258`, `pix_y = 36`.
  - Expect `rom_addr = 8'h02` and `score_on = 1` at N+2 (glyph row `01111100`, bit 6).
  - Present `pix_x = 256` → `score_on = 0` (bit 7).
- **Boundaries:**
  - Present `pix_x = 255`, `271`, `272` with `pix_y = 31`, `32`, `63`, `64`.
  - Expect a hit only at x∈[256,271] and y∈[32,63]; `video_on = 0` → `score_on = 0` always.
- **Tearing:** score changes mid-frame → `rom_addr` digit field unchanged until `frame_tick`, then reflects the new score.
